// File: rtl/grid_marker_if.sv
// rtl/grid_marker_if.sv - request/status and VGA pixel bus for grid_marker
//
// Purpose: bundles the mark request (start plus captured fields), the status
// outputs (busy/done/err) and the one-pixel-per-clock VGA plot bus.
// Ports (signals):
//   start, x_square, y_square, player, mode, colour : request, driven by master
//   busy, done, err                                  : status, driven by slave
//   vga_x, vga_y, vga_colour, vga_plot               : pixel bus, driven by slave
interface grid_marker_if #(
  parameter int IDXW = 4
);
  logic            start;
  logic [IDXW-1:0] x_square;
  logic [IDXW-1:0] y_square;
  logic            player;
  logic [1:0]      mode;
  logic [2:0]      colour;
  logic            busy;
  logic            done;
  logic            err;
  logic [8:0]      vga_x;
  logic [7:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot;

  modport master (
    output start, x_square, y_square, player, mode, colour,
    input  busy, done, err, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, x_square, y_square, player, mode, colour,
    output busy, done, err, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/grid_marker.sv
// rtl/grid_marker.sv - paints one cross/fill/outline/clear mark into a board cell
//
// Purpose: on start (sampled only when idle) draws one mark into one cell of
// one of two boards, one pixel per clock, then pulses done for one cycle.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : grid_marker_if slave (request in; busy/done/err and VGA pixel bus out)
module grid_marker #(
  parameter int GRID_N = 10,
  parameter int CELL   = 12,
  parameter int PITCH  = 14,
  parameter int BASEX0 = 10,
  parameter int BASEX1 = 178,
  parameter int BASEY  = 91,
  parameter int IDXW   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  grid_marker_if.slave  bus
);

  localparam int            CW   = (CELL > 2) ? $clog2(CELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(CELL - 1);

  localparam logic [1:0] M_CROSS   = 2'd0;
  localparam logic [1:0] M_OUTLINE = 2'd2;
  localparam logic [1:0] M_CLEAR   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CROSS_A, S_CROSS_B, S_RASTER, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] xs_q, xs_d;
  logic [IDXW-1:0] ys_q, ys_d;
  logic            player_q, player_d;
  logic [1:0]      mode_q, mode_d;
  logic [2:0]      colour_q, colour_d;
  logic            err_q, err_d;
  logic [8:0]      bx_q, bx_d;
  logic [7:0]      by_q, by_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      player_q <= 1'b0;
      mode_q   <= 2'd0;
      colour_q <= 3'd0;
      err_q    <= 1'b0;
      bx_q     <= 9'd0;
      by_q     <= 8'd0;
      i_q      <= '0;
      j_q      <= '0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      player_q <= player_d;
      mode_q   <= mode_d;
      colour_q <= colour_d;
      err_q    <= err_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      i_q      <= i_d;
      j_q      <= j_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    player_d = player_q;
    mode_d   = mode_q;
    colour_d = colour_q;
    err_d    = err_q;
    bx_d     = bx_q;
    by_d     = by_q;
    i_d      = i_q;
    j_d      = j_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          xs_d     = bus.x_square;
          ys_d     = bus.y_square;
          player_d = bus.player;
          mode_d   = bus.mode;
          colour_d = bus.colour;
          if ((32'(bus.x_square) >= GRID_N) || (32'(bus.y_square) >= GRID_N)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // Cell origin is computed from the captured indices, never the live inputs.
        bx_d    = (player_q ? 9'(BASEX1) : 9'(BASEX0)) + 9'(PITCH) * 9'(xs_q);
        by_d    = 8'(BASEY) + 8'(PITCH) * 8'(ys_q);
        i_d     = '0;
        j_d     = '0;
        state_d = (mode_q == M_CROSS) ? S_CROSS_A : S_RASTER;
      end
      S_CROSS_A: begin
        if (i_q == LAST) begin
          i_d     = '0;
          state_d = S_CROSS_B;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_CROSS_B: begin
        if (i_q == LAST) begin
          i_d     = '0;
          state_d = S_DONE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_RASTER: begin
        if (i_q == LAST) begin
          i_d = '0;
          if (j_q == LAST) begin
            j_d     = '0;
            state_d = S_DONE;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel outputs decode only registered state and counters.
  logic       plot;
  logic [8:0] px;
  logic [7:0] py;

  always_comb begin
    plot = 1'b0;
    px   = 9'd0;
    py   = 8'd0;
    case (state_q)
      S_CROSS_A: begin
        plot = 1'b1;
        px   = bx_q + 9'(i_q);
        py   = by_q + 8'(i_q);
      end
      S_CROSS_B: begin
        plot = 1'b1;
        px   = bx_q + 9'(LAST) - 9'(i_q);
        py   = by_q + 8'(i_q);
      end
      S_RASTER: begin
        plot = (mode_q != M_OUTLINE) || (i_q == '0) || (i_q == LAST) ||
               (j_q == '0) || (j_q == LAST);
        px   = bx_q + 9'(i_q);
        py   = by_q + 8'(j_q);
      end
      default: ;
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_DONE) && err_q;
  assign bus.vga_plot   = plot;
  assign bus.vga_x      = plot ? px : 9'd0;
  assign bus.vga_y      = plot ? py : 8'd0;
  assign bus.vga_colour = (mode_q == M_CLEAR) ? 3'd0 : colour_q;

endmodule

// File: tb/tb_grid_marker.sv
// tb/tb_grid_marker.sv - self-checking bench for grid_marker
module tb_grid_marker;

  localparam int G  = 10;
  localparam int C  = 12;
  localparam int P  = 14;
  localparam int X0 = 10;
  localparam int X1 = 178;
  localparam int Y0 = 91;

  logic clk;
  logic rst_n;

  grid_marker_if #(.IDXW(4)) bus ();

  grid_marker #(
    .GRID_N(G), .CELL(C), .PITCH(P), .BASEX0(X0), .BASEX1(X1), .BASEY(Y0), .IDXW(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int exp_x[$];
  int exp_y[$];
  int exp_done;
  int exp_err;
  int exp_col;
  int obs_x[$];
  int obs_y[$];
  int obs_c[$];
  int done_cyc;
  int err_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int ox(int k);
    return (k < obs_x.size()) ? obs_x[k] : -1;
  endfunction

  function automatic int oy(int k);
    return (k < obs_y.size()) ? obs_y[k] : -1;
  endfunction

  // Reference: list of pixels the mark must paint, in draw order.
  task automatic model(input int p, input int xs, input int ys, input int m, input int col);
    int bx, by, n;
    exp_x.delete();
    exp_y.delete();
    exp_col = (m == 3) ? 0 : col;
    if (xs >= G || ys >= G) begin
      exp_done = 1;
      exp_err  = 1;
      return;
    end
    exp_err = 0;
    bx = (p != 0 ? X1 : X0) + P * xs;
    by = Y0 + P * ys;
    if (m == 0) begin
      for (int k = 0; k < C; k++) begin exp_x.push_back(bx + k); exp_y.push_back(by + k); end
      for (int k = 0; k < C; k++) begin exp_x.push_back(bx + C - 1 - k); exp_y.push_back(by + k); end
      n = 2 * C;
    end else begin
      for (int r = 0; r < C; r++)
        for (int c = 0; c < C; c++)
          if (m != 2 || c == 0 || c == C - 1 || r == 0 || r == C - 1) begin
            exp_x.push_back(bx + c);
            exp_y.push_back(by + r);
          end
      n = C * C;
    end
    exp_done = n + 2;
  endtask

  task automatic launch(input int p, input int xs, input int ys, input int m, input int col);
    model(p, xs, ys, m, col);
    bus.player   = p[0];
    bus.x_square = xs[3:0];
    bus.y_square = ys[3:0];
    bus.mode     = m[1:0];
    bus.colour   = col[2:0];
    bus.start    = 1'b1;
  endtask

  task automatic collect(input bit keep_start, input int new_x, input string tag);
    int c, stray, colbad, bad, n;
    obs_x.delete();
    obs_y.delete();
    obs_c.delete();
    done_cyc = -1;
    err_seen = 0;
    stray = 0;
    colbad = 0;
    c = 0;
    while (c < 400) begin
      cyc();
      c++;
      if (c == 1) begin
        if (keep_start) bus.x_square = new_x[3:0];
        else bus.start = 1'b0;
        check({tag, "_c1_busy"}, 32'(bus.busy), 1);
        check({tag, "_c1_plot"}, 32'(bus.vga_plot), 0);
      end
      if (bus.vga_plot) begin
        obs_x.push_back(int'(bus.vga_x));
        obs_y.push_back(int'(bus.vga_y));
        obs_c.push_back(int'(bus.vga_colour));
        if (int'(bus.vga_colour) != exp_col) colbad++;
      end else if (bus.vga_x != 0 || bus.vga_y != 0) begin
        stray++;
      end
      if (!bus.done && bus.err) stray++;
      if (bus.done) begin
        done_cyc = c;
        err_seen = int'(bus.err);
        break;
      end
    end
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_err"}, err_seen, exp_err);
    check({tag, "_plot_count"}, obs_x.size(), exp_x.size());
    bad = 0;
    n = (obs_x.size() < exp_x.size()) ? obs_x.size() : exp_x.size();
    for (int k = 0; k < n; k++)
      if (obs_x[k] != exp_x[k] || obs_y[k] != exp_y[k]) bad++;
    check({tag, "_pixel_mismatches"}, bad, 0);
    check({tag, "_colour_mismatches"}, colbad, 0);
    check({tag, "_stray_outputs"}, stray, 0);
    cyc();
    check({tag, "_idle_busy"}, 32'(bus.busy), 0);
    check({tag, "_idle_done"}, 32'(bus.done), 0);
  endtask

  initial begin
    int edge_bad, hit, cnt, m, p, xs, ys, col;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.x_square = '0;
    bus.y_square = '0;
    bus.player   = 1'b0;
    bus.mode     = 2'd0;
    bus.colour   = 3'd0;
    cyc();
    cyc();
    check("reset_outputs",
          {14'd0, bus.busy, bus.done, bus.err, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}, 0);
    rst_n = 1'b1;
    cyc();

    launch(0, 3, 5, 0, 4);
    collect(0, 0, "cross");
    check("cross_p1_x", ox(0), 52);
    check("cross_p1_y", oy(0), 161);
    check("cross_p12_x", ox(11), 63);
    check("cross_p12_y", oy(11), 172);
    check("cross_p13_x", ox(12), 63);
    check("cross_p13_y", oy(12), 161);
    check("cross_p24_x", ox(23), 52);
    check("cross_p24_y", oy(23), 172);
    check("cross_done_26", done_cyc, 26);
    check("cross_colour", (obs_c.size() > 0) ? obs_c[0] : -1, 4);

    launch(1, 0, 0, 1, 2);
    collect(0, 0, "fill");
    check("fill_count", obs_x.size(), 144);
    check("fill_first_x", ox(0), 178);
    check("fill_first_y", oy(0), 91);
    check("fill_last_x", ox(143), 189);
    check("fill_last_y", oy(143), 102);
    check("fill_done_146", done_cyc, 146);

    launch(0, 9, 9, 2, 7);
    collect(0, 0, "outline");
    check("outline_count", obs_x.size(), 44);
    edge_bad = 0;
    hit = 0;
    for (int k = 0; k < obs_x.size(); k++) begin
      if (!(obs_x[k] == 136 || obs_x[k] == 147 || obs_y[k] == 217 || obs_y[k] == 228)) edge_bad++;
      if (obs_x[k] == 137 && obs_y[k] == 218) hit++;
    end
    check("outline_on_edges", edge_bad, 0);
    check("outline_no_inner", hit, 0);

    launch(0, 9, 9, 3, 7);
    collect(0, 0, "clear");
    check("clear_count", obs_x.size(), 144);
    check("clear_colour", (obs_c.size() > 0) ? obs_c[0] : -1, 0);

    launch(0, 10, 2, 1, 5);
    collect(0, 0, "oob");
    check("oob_done_c1", done_cyc, 1);

    launch(0, 2, 3, 1, 5);
    cnt = 0;
    for (int k = 0; k < 200 && cnt < 20; k++) begin
      cyc();
      if (k == 0) bus.start = 1'b0;
      if (bus.vga_plot) cnt++;
    end
    check("rst_plot20", cnt, 20);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("rst_mid_outputs",
          {14'd0, bus.busy, bus.done, bus.err, bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}, 0);
    launch(1, 4, 6, 0, 3);
    collect(0, 0, "post_rst");

    launch(0, 2, 2, 0, 6);
    collect(1, 7, "held_first");
    model(0, 7, 2, 0, 6);
    collect(0, 0, "held_second");
    check("held_second_abs_done", 27 + done_cyc, 53);

    for (int r = 0; r < 10; r++) begin
      m   = int'($urandom_range(0, 3));
      p   = int'($urandom_range(0, 1));
      xs  = int'($urandom_range(0, 11));
      ys  = int'($urandom_range(0, 10));
      col = int'($urandom_range(0, 7));
      launch(p, xs, ys, m, col);
      collect(0, 0, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
